// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multiply/divide unit sequencing, branch flush.
// Optional HAZ_STALL_CNT_EN adds a saturating stall-cycle counter on StallCount.
module hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic        UsesRt_ID,
  input  logic        MemRead_EX,
  input  logic [4:0]  Rt_EX,
  input  logic        MduStart_ID,
  input  logic        MduIsDiv_ID,
  input  logic        MfHiLo_ID,
  input  logic        BranchTaken_ID,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        MduBusy,
  output logic        MduDone,
  output logic [15:0] StallCount
);

  // state | meaning
  // RUN   | no MDU operation in flight
  // MDU   | mult/div running, mdu_cnt counts down to the done cycle
  typedef enum logic {RUN, MDU} state_t;

  state_t     state, state_nxt;
  logic [5:0] mdu_cnt, mdu_cnt_nxt;
  logic       load_use, mdu_haz, stall;

  assign load_use = MemRead_EX && (Rt_EX != 5'd0) &&
                    ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
  assign mdu_haz  = (state == MDU) && (MfHiLo_ID || MduStart_ID);
  assign stall    = load_use || mdu_haz;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= RUN;
      mdu_cnt <= 6'd0;
    end else begin
      state   <= state_nxt;
      mdu_cnt <= mdu_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    mdu_cnt_nxt = mdu_cnt;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    MduBusy     = 1'b0;
    MduDone     = 1'b0;

    // a stalled cycle never flushes; the branch is re-presented once the stall clears
    if (stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else begin
      IFID_Flush  = BranchTaken_ID;
    end

    case (state)
      RUN: begin
        if (MduStart_ID && !stall) begin
          mdu_cnt_nxt = MduIsDiv_ID ? 6'd31 : 6'd3;
          state_nxt   = MDU;
        end
      end
      MDU: begin
        MduBusy = 1'b1;
        if (mdu_cnt == 6'd0) begin
          MduDone   = 1'b1;
          state_nxt = RUN;
        end else begin
          mdu_cnt_nxt = mdu_cnt - 6'd1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef HAZ_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge Clk) begin
    if (Rst)
      stall_cnt <= 16'd0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 16'd0;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide ports, clock and reset first: Clk in 1 (clock, all state on posedge); Rst in 1 (reset, synchronous, active-high).
REQ-002 SHALL provide Rs_ID in 5, Rt_ID in 5: source register numbers of the instruction in ID.
REQ-003 SHALL provide UsesRt_ID in 1: the ID instruction reads Rt.
REQ-004 SHALL provide MemRead_EX in 1, Rt_EX in 5: the EX instruction is a load, and its destination.
REQ-005 SHALL provide MduStart_ID in 1, MduIsDiv_ID in 1: the ID instruction is mult (0) or div (1).
REQ-006 SHALL provide MfHiLo_ID in 1: the ID instruction reads HI or LO.
REQ-007 SHALL provide BranchTaken_ID in 1: the branch in ID resolved as taken.
REQ-008 SHALL provide outputs PCWrite 1, IFID_Write 1, IFID_Flush 1, IDEX_Bubble 1 (forces ID/EX control byte to zero), MduBusy 1, MduDone 1, StallCount 16.

Function
REQ-009 SHALL implement a two-state FSM, RUN and MDU, plus a 6-bit down-counter MduCnt.
REQ-010 SHALL flag LoadUse=1 when MemRead_EX=1, Rt_EX!=0, and (Rt_EX==Rs_ID or (UsesRt_ID=1 and Rt_EX==Rt_ID)), in any state.
REQ-011 SHALL flag MduHaz=1 when state is MDU and (MfHiLo_ID=1 or MduStart_ID=1).
REQ-012 SHALL define Stall = LoadUse or MduHaz; when Stall=1: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
REQ-013 SHALL, when Stall=0: PCWrite=1, IFID_Write=1, IDEX_Bubble=0, IFID_Flush=BranchTaken_ID.
REQ-014 SHALL give priority LoadUse > MduHaz > branch flush; a taken branch is ignored in any stalled cycle and must be re-presented.
REQ-015 SHALL be combinational on all stall and flush outputs, with zero-cycle latency from inputs.
REQ-016 SHALL accept a start in RUN only when MduStart_ID=1 and Stall=0: load MduCnt with 3 for mult or 31 for div, and go to MDU.
REQ-017 SHALL, in MDU, drive MduBusy=1 and decrement MduCnt each cycle; when MduCnt==0, pulse MduDone=1 for that cycle and go to RUN next cycle.
REQ-018 SHALL therefore hold MduBusy for 4 cycles (mult) or 32 cycles (div) after the accept cycle, with MduDone in the last busy cycle.
REQ-019 SHALL drive MduBusy=0 and MduDone=0 in RUN.
REQ-020 SHALL release an instruction blocked by MduHaz in the first RUN cycle after MduDone; a blocked MduStart_ID is accepted in that same cycle.
REQ-021 SHALL evaluate a load-use hazard during MDU independently, without disturbing MduCnt.

Reset
REQ-022 SHALL, when Rst=1 at posedge, set state=RUN, MduCnt=0 and StallCount=0, aborting any MDU operation with no MduDone.
REQ-023 SHALL, in the cycle after reset, drive PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0, MduBusy=0 and MduDone=0, given inactive inputs.

Configuration
REQ-024 SHALL, with HAZ_STALL_CNT_EN defined, increment StallCount by 1 on each posedge where Stall=1 and Rst=0, saturating at 16'hFFFF.
REQ-025 SHALL, without HAZ_STALL_CNT_EN, keep the StallCount port, drive it constantly to 0, and synthesize no counter register.

Verification
REQ-026 SHALL cover load-use: MemRead_EX=1, Rt_EX=5, Rs_ID=5 -> that cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; with Rt_EX=0 -> no stall.
REQ-027 SHALL cover mult: MduStart_ID=1, MduIsDiv_ID=0 accepted at T -> MduBusy=1 T+1..T+4, MduDone=1 only at T+4, RUN at T+5.
REQ-028 SHALL cover div with MfHiLo_ID held from T+1 -> stall T+1..T+32, MduDone at T+32, PCWrite=1 at T+33; with macro, StallCount=32.
REQ-029 SHALL cover simultaneous LoadUse=1 and BranchTaken_ID=1 -> IFID_Flush=0 and IDEX_Bubble=1; next cycle, LoadUse=0 and branch still taken -> IFID_Flush=1.
REQ-030 SHALL cover Rst=1 at busy cycle 10 of a div -> next cycle MduBusy=0, no MduDone, StallCount=0; a subsequent mult runs the full 4 cycles.
